// File: rtl/bram_sdp.sv
// Simple dual-port block RAM: one write port, one independent registered read
// port, single clock. Depth is 2**ADDR_W words of DATA_W bits. The storage
// array carries no reset so that it maps onto FPGA block RAM; only the read
// data register is reset.
module bram_sdp #(
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned ADDR_W        = 8,
  // Same-address read-during-write: 0 = read-first (old data), 1 = write-first.
  parameter int unsigned WRITE_THROUGH = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [ADDR_W-1:0] addr_out,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  // NOTE: the array has a power-up value but no reset branch; a reset would
  // force it into flip-flops instead of block RAM.
  logic [DATA_W-1:0] mem_q [DEPTH] = '{default: '0};
  logic [DATA_W-1:0] data_out_q = '0;

  logic wr_fire;
  logic rd_fire;
  logic collide;

  // Qualify both ports with reset and detect a same-address collision.
  // NOTE: every signal in a combinational block is assigned on every path,
  // so no latch can be inferred.
  always_comb begin
    wr_fire = wr_en & ~rst;
    rd_fire = rd_en & ~rst;
    collide = wr_fire & rd_fire & (addr_in == addr_out);
  end

  // Write port: store data_in when enabled and not in reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, which is also what gives read-first behaviour.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_q[addr_in] <= data_in;
    end
  end

  // Read port: registered read with one-cycle latency; holds when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_q <= '0;
    end else if (rd_fire) begin
      if ((WRITE_THROUGH != 0) && collide) begin
        data_out_q <= data_in;
      end else begin
        data_out_q <= mem_q[addr_out];
      end
    end
  end

  assign data_out = data_out_q;

endmodule

// File: tb/tb_bram_sdp.sv
// Self-checking bench for bram_sdp. Two instances share every input: one
// read-first and one write-first. A flat reference array plus the collision
// rule predicts both outputs after each clock edge.
module tb_bram_sdp;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 2 ** ADDR_W;

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] addr_in;
  logic [ADDR_W-1:0] addr_out;
  logic              wr_en;
  logic              rd_en;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] dout_rf;
  logic [DATA_W-1:0] dout_wt;

  bram_sdp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .WRITE_THROUGH(0)) dut_rf (
    .clk      (clk),
    .rst      (rst),
    .addr_in  (addr_in),
    .addr_out (addr_out),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .data_in  (data_in),
    .data_out (dout_rf)
  );

  bram_sdp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .WRITE_THROUGH(1)) dut_wt (
    .clk      (clk),
    .rst      (rst),
    .addr_in  (addr_in),
    .addr_out (addr_out),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .data_in  (data_in),
    .data_out (dout_wt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state.
  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic [DATA_W-1:0] exp_rf;
  logic [DATA_W-1:0] exp_wt;

  int total;
  int passed;

  task automatic check(input string tag, input logic [DATA_W-1:0] observed,
                       input logic [DATA_W-1:0] expected);
    total++;
    assert (observed === expected) passed++;
    else $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, observed, expected);
  endtask

  // Apply one cycle of inputs, advance the model across the edge, then
  // compare both instances against it 1 ns after the edge.
  task automatic step(input string tag, input logic r, input logic we,
                      input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                      input logic re, input logic [ADDR_W-1:0] ra);
    rst      = r;
    wr_en    = we;
    addr_in  = wa;
    data_in  = wd;
    rd_en    = re;
    addr_out = ra;
    @(posedge clk);
    if (r) begin
      exp_rf = '0;
      exp_wt = '0;
    end else begin
      if (re) begin
        exp_rf = ref_mem[ra];
        exp_wt = (we && (wa == ra)) ? wd : ref_mem[ra];
      end
      if (we) ref_mem[wa] = wd;
    end
    #1;
    check({tag, "/rf"}, dout_rf, exp_rf);
    check({tag, "/wt"}, dout_wt, exp_wt);
  endtask

  initial begin
    total  = 0;
    passed = 0;
    exp_rf = '0;
    exp_wt = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

    // Reset
    step("reset0", 1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 8'd0);
    step("reset1", 1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 8'd0);
    check("reset_rf", dout_rf, 8'h00);
    check("reset_wt", dout_wt, 8'h00);

    // Pipelined write/read
    step("pipe_w1", 1'b0, 1'b1, 8'd1, 8'd1, 1'b0, 8'd0);
    step("pipe_r1", 1'b0, 1'b1, 8'd2, 8'd2, 1'b1, 8'd1);
    check("pipe_rd1", dout_rf, 8'd1);
    step("pipe_r2", 1'b0, 1'b1, 8'd3, 8'd3, 1'b1, 8'd2);
    check("pipe_rd2", dout_rf, 8'd2);
    step("pipe_r3", 1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 8'd3);
    check("pipe_rd3", dout_wt, 8'd3);

    // Hold with rd_en low while the read address moves
    step("hold1", 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 8'd1);
    step("hold2", 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 8'd2);
    check("hold_rf", dout_rf, 8'd3);
    check("hold_wt", dout_wt, 8'd3);

    // Same-address collision at address 5
    step("coll_pre", 1'b0, 1'b1, 8'd5, 8'h11, 1'b0, 8'd0);
    step("coll", 1'b0, 1'b1, 8'd5, 8'h22, 1'b1, 8'd5);
    check("coll_rf_old", dout_rf, 8'h11);
    check("coll_wt_new", dout_wt, 8'h22);
    step("coll_after", 1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 8'd5);
    check("coll_after_rf", dout_rf, 8'h22);

    // Address boundaries and an unwritten location
    step("bnd_w0", 1'b0, 1'b1, 8'd0, 8'hA5, 1'b0, 8'd0);
    step("bnd_w255", 1'b0, 1'b1, 8'd255, 8'h5A, 1'b1, 8'd0);
    check("bnd_rd0", dout_rf, 8'hA5);
    step("bnd_r255", 1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 8'd255);
    check("bnd_rd255", dout_wt, 8'h5A);
    step("unwritten", 1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 8'd7);
    check("unwritten7", dout_rf, 8'h00);

    // Reset mid-operation discards both the write and the read
    step("rst_pre", 1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 8'd255);
    check("rst_pre_5a", dout_rf, 8'h5A);
    step("rst_mid", 1'b1, 1'b1, 8'd0, 8'hFF, 1'b1, 8'd0);
    check("rst_mid_rf", dout_rf, 8'h00);
    check("rst_mid_wt", dout_wt, 8'h00);
    step("rst_post", 1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 8'd0);
    check("rst_post_a5", dout_rf, 8'hA5);

    // Random traffic; a narrow address window keeps collisions frequent
    for (int n = 0; n < 1000; n++) begin
      logic              r_rst;
      logic              r_we;
      logic              r_re;
      logic [ADDR_W-1:0] r_wa;
      logic [ADDR_W-1:0] r_ra;
      logic [DATA_W-1:0] r_wd;
      r_rst = ($urandom_range(0, 49) == 0);
      r_we  = 1'($urandom_range(0, 1));
      r_re  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        r_wa = ADDR_W'($urandom_range(0, DEPTH - 1));
        r_ra = ADDR_W'($urandom_range(0, DEPTH - 1));
      end else begin
        r_wa = ADDR_W'($urandom_range(0, 15));
        r_ra = ADDR_W'($urandom_range(0, 15));
      end
      r_wd = DATA_W'($urandom);
      step("rand", r_rst, r_we, r_wa, r_wd, r_re, r_ra);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
